// File: rtl/t07_regfile_mp.sv
// Parametrised multi-port register file: NRD read ports, writeback + load-return
// write ports, write-to-read bypass, optional registered read, busy scoreboard.
module t07_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                freeze_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic [XLEN-1:0]     wr0_data_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    input  logic [XLEN-1:0]     wr1_data_i,
    input  logic                rsv_en_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic [NREGS-1:0]    busy_vec_o
);

    localparam logic [NREGS-1:0] ZMASK = (ZERO_REG != 0) ? NREGS'(1) : '0;

    logic             w_upd;
    logic             w_wr0_ok;
    logic             w_wr1_ok;
    logic             w_rsv_ok;
    logic [XLEN-1:0]  r_regs     [NREGS];
    logic [XLEN-1:0]  w_reg_next [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_upd    = enable & ~freeze_i;
    assign w_wr0_ok = w_upd & wr0_en_i & ~is_zero_reg(wr0_addr_i);
    assign w_wr1_ok = w_upd & wr1_en_i & ~is_zero_reg(wr1_addr_i);
    assign w_rsv_ok = w_upd & rsv_en_i & ~is_zero_reg(rsv_addr_i);

    // Next-state per register; all update gating is folded into the *_ok strobes,
    // so these equal the current value whenever nothing commits.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic w_wr0_hit;
            logic w_wr1_hit;
            logic w_rsv_hit;
            assign w_wr0_hit = w_wr0_ok && (wr0_addr_i == AW'(gi));
            assign w_wr1_hit = w_wr1_ok && (wr1_addr_i == AW'(gi));
            assign w_rsv_hit = w_rsv_ok && (rsv_addr_i == AW'(gi));
            assign w_reg_next[gi]  = w_wr1_hit ? wr1_data_i :
                                     w_wr0_hit ? wr0_data_i : r_regs[gi];
            // A reserve beats a same-cycle commit: the new producer owns the register.
            assign w_busy_next[gi] = w_rsv_hit | (r_busy[gi] & ~(w_wr0_hit | w_wr1_hit));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= w_reg_next[i];
            r_busy <= w_busy_next;
        end
    end

    assign busy_vec_o = r_busy & ~ZMASK;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] w_addr;
            assign w_addr = rd_addr_i[gi*AW +: AW];

            if (READ_REG != 0) begin : g_registered
                logic [XLEN-1:0] r_rd_data;
                logic            r_rd_busy;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_rd_data <= '0;
                        r_rd_busy <= 1'b0;
                    end else if (w_upd) begin
                        r_rd_data <= is_zero_reg(w_addr) ? '0 : w_reg_next[w_addr];
                        r_rd_busy <= w_busy_next[w_addr] & ~is_zero_reg(w_addr);
                    end
                end
                assign rd_data_o[gi*XLEN +: XLEN] = r_rd_data;
                assign rd_busy_o[gi]              = r_rd_busy;
            end else begin : g_comb
                logic            w_wr_hit;
                logic            w_rsv_hit;
                logic [XLEN-1:0] w_data;
                assign w_wr_hit  = (w_wr0_ok && (wr0_addr_i == w_addr)) ||
                                   (w_wr1_ok && (wr1_addr_i == w_addr));
                assign w_rsv_hit = w_rsv_ok && (rsv_addr_i == w_addr);
                assign w_data    = (BYPASS != 0) ? w_reg_next[w_addr] : r_regs[w_addr];
                assign rd_data_o[gi*XLEN +: XLEN] = is_zero_reg(w_addr) ? '0 : w_data;
                assign rd_busy_o[gi] = (w_wr_hit && !w_rsv_hit) ? 1'b0
                                     : (r_busy[w_addr] & ~is_zero_reg(w_addr));
            end
        end
    endgenerate

endmodule

// File: tb/tb_t07_regfile_mp.sv
// Directed bench: three instances (bypass/comb, no-bypass/comb, registered read)
// share one stimulus stream; each check compares against hand-computed values.
module tb_t07_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst, enable, freeze_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic                wr0_en_i, wr1_en_i, rsv_en_i;
    logic [AW-1:0]       wr0_addr_i, wr1_addr_i, rsv_addr_i;
    logic [XLEN-1:0]     wr0_data_i, wr1_data_i;

    logic [NRD*XLEN-1:0] rd_data_a, rd_data_b, rd_data_c;
    logic [NRD-1:0]      rd_busy_a, rd_busy_b, rd_busy_c;
    logic [NREGS-1:0]    busy_vec_a, busy_vec_b, busy_vec_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    t07_regfile_mp #(.BYPASS(1), .READ_REG(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .freeze_i(freeze_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
        .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
        .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_a));

    t07_regfile_mp #(.BYPASS(0), .READ_REG(0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .freeze_i(freeze_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
        .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_b));

    t07_regfile_mp #(.BYPASS(1), .READ_REG(1)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .freeze_i(freeze_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_c), .rd_busy_o(rd_busy_c),
        .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
        .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr0_en_i = 1'b0;
        wr1_en_i = 1'b0;
        rsv_en_i = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr0_en_i = 1'b1; wr0_addr_i = a; wr0_data_i = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr1_en_i = 1'b1; wr1_addr_i = a; wr1_data_i = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_en_i = 1'b1; rsv_addr_i = a;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        rd_addr_i = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; freeze_i = 1'b0;
        rd_addr_i = '0;
        wr0_addr_i = '0; wr1_addr_i = '0; rsv_addr_i = '0;
        wr0_data_i = '0; wr1_data_i = '0;
        clr();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd(5, 5); #2;
        chk("rst_busyvec", 64'(busy_vec_a), 64'h0);
        chk("rst_rd_a", 64'(rd_data_a[31:0]), 64'h0);
        chk("rst_rd_c", 64'(rd_data_c), 64'h0);

        // Write r5 then reset clears it
        wr0(5, 32'hDEADBEEF); #2;
        chk("byp_r5_a", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
        chk("nobyp_r5_b", 64'(rd_data_b[31:0]), 64'h0);
        tick(); clr(); #2;
        chk("r5_b", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
        chk("r5_c", 64'(rd_data_c[31:0]), 64'hDEADBEEF);
        rst = 1'b1; tick(); rst = 1'b0; #2;
        chk("r5_rst_a", 64'(rd_data_a[31:0]), 64'h0);
        chk("rst2_bvec", 64'(busy_vec_a), 64'h0);
        chk("rst2_rd_c", 64'(rd_data_c), 64'h0);

        // Dual write, different addresses
        wr0(3, 32'h11); wr1(7, 32'h22); rd(7, 3);
        tick(); clr(); #2;
        chk("dual_r3", 64'(rd_data_a[31:0]), 64'h11);
        chk("dual_r7", 64'(rd_data_a[63:32]), 64'h22);

        // Dual write, same address: port 1 wins
        wr0(9, 32'hAA); wr1(9, 32'hBB); rd(9, 9); #2;
        chk("same_byp_a", 64'(rd_data_a[31:0]), 64'hBB);
        chk("same_old_b", 64'(rd_data_b[31:0]), 64'h0);
        tick(); clr(); #2;
        chk("same_r9_b", 64'(rd_data_b[31:0]), 64'hBB);
        chk("same_r9_c", 64'(rd_data_c[63:32]), 64'hBB);

        // Bypass vs. no bypass vs. registered read
        rd(4, 4); wr0(4, 32'h1234); #2;
        chk("byp_r4_a", 64'(rd_data_a[31:0]), 64'h1234);
        chk("nobyp_r4_b", 64'(rd_data_b[31:0]), 64'h0);
        chk("regrd_hold_c", 64'(rd_data_c[31:0]), 64'hBB);
        tick(); clr(); #2;
        chk("r4_next_b", 64'(rd_data_b[31:0]), 64'h1234);
        chk("r4_lat_c", 64'(rd_data_c[31:0]), 64'h1234);

        // Zero register
        wr0(0, 32'hFFFFFFFF); rsv(0); rd(0, 0); #2;
        chk("zero_byp_a", 64'(rd_data_a[31:0]), 64'h0);
        tick(); clr(); #2;
        chk("zero_r0_a", 64'(rd_data_a[31:0]), 64'h0);
        chk("zero_bvec", 64'(busy_vec_a), 64'h0);

        // Scoreboard: reserve
        rsv(6); rd(6, 6); #2;
        chk("rsv_now_busy", 64'(rd_busy_a), 64'h0);
        tick(); clr(); #2;
        chk("rsv_bvec", 64'(busy_vec_a), 64'h40);
        chk("rsv_busy_a", 64'(rd_busy_a), 64'h3);
        chk("rsv_busy_c", 64'(rd_busy_c), 64'h3);

        // Scoreboard: load return clears
        wr1(6, 32'h55); #2;
        chk("ret_busy_a", 64'(rd_busy_a), 64'h0);
        chk("ret_bvec_pre", 64'(busy_vec_a), 64'h40);
        tick(); clr(); #2;
        chk("ret_bvec", 64'(busy_vec_a), 64'h0);
        chk("ret_r6", 64'(rd_data_a[31:0]), 64'h55);
        chk("ret_busy_c", 64'(rd_busy_c), 64'h0);

        // Scoreboard: reserve and write same cycle -> stays busy
        rsv(6); wr0(6, 32'h66); #2;
        chk("rw_byp_a", 64'(rd_data_a[31:0]), 64'h66);
        chk("rw_busy_now", 64'(rd_busy_a), 64'h0);
        tick(); clr(); #2;
        chk("rw_bvec", 64'(busy_vec_a), 64'h40);
        chk("rw_r6", 64'(rd_data_a[31:0]), 64'h66);
        chk("rw_busy_c", 64'(rd_busy_c), 64'h3);
        chk("rw_data_c", 64'(rd_data_c[31:0]), 64'h66);
        wr0(6, 32'h66); tick(); clr(); #2;
        chk("rw_clear", 64'(busy_vec_a), 64'h0);

        // enable=0 blocks writes and registered read
        enable = 1'b0; wr0(3, 32'h99); rd(3, 3); #2;
        chk("en0_byp_a", 64'(rd_data_a[31:0]), 64'h11);
        tick(); clr(); enable = 1'b1; #2;
        chk("en0_r3_a", 64'(rd_data_a[31:0]), 64'h11);
        chk("en0_hold_c", 64'(rd_data_c[31:0]), 64'h66);

        // Freeze with registered read
        rd(2, 2); tick(); #2;
        chk("frz_pre_c", 64'(rd_data_c), 64'h0);
        freeze_i = 1'b1; wr0(2, 32'h77); rd(2, 3); #2;
        chk("frz_nobyp_a", 64'(rd_data_a[63:32]), 64'h0);
        tick(); clr(); freeze_i = 1'b0; #2;
        chk("frz_r2_a", 64'(rd_data_a[63:32]), 64'h0);
        chk("frz_hold_c", 64'(rd_data_c), 64'h0);

        // Release: write r2, then present r2 and see it one cycle later
        wr0(2, 32'h77); rd(3, 3); tick(); clr(); rd(2, 2); #2;
        chk("rel_prev_c", 64'(rd_data_c[31:0]), 64'h11);
        tick(); #2;
        chk("rel_r2_c", 64'(rd_data_c[31:0]), 64'h77);
        chk("rel_r2_a", 64'(rd_data_a[31:0]), 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t07_regfile_mp.md
Name: t07_regfile_mp

Overview:
- Parametrised multi-port register file for the team 07 CPU; replaces the fixed 32x32, 2-read/1-write file.
- Width, depth and read-port count are set by parameters. Two write ports are provided: writeback and late load return.
- Adds write-to-read bypass, an optional registered-read mode, and a per-register busy scoreboard so the control unit can detect load-use hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers (power of 2, >=2); AW = clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 register 0 reads 0 and is never written or marked busy.
- BYPASS, 1, if 1 same-cycle writes are forwarded to read outputs.
- READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  from control unit; 0 blocks all state updates.
- freeze_i  in  1  1 blocks all state updates (same effect as enable=0).
- rd_addr_i  in  NRD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  packed read data; port k = bits [k*XLEN +: XLEN].
- rd_busy_o  out  NRD  busy bit of the register addressed by each read port.
- wr0_en_i  in  1  write port 0 enable (writeback).
- wr0_addr_i  in  AW  write port 0 address.
- wr0_data_i  in  XLEN  write port 0 data.
- wr1_en_i  in  1  write port 1 enable (load return).
- wr1_addr_i  in  AW  write port 1 address.
- wr1_data_i  in  XLEN  write port 1 data.
- rsv_en_i  in  1  reserve request: mark rsv_addr_i busy (load issued).
- rsv_addr_i  in  AW  register to reserve.
- busy_vec_o  out  NREGS  full scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst=1 at rising edge): all registers 0, all busy bits 0, registered read outputs 0. Reset overrides every other input, including a write or reserve in the same cycle.
- upd = enable & ~freeze_i. When upd=0, registers, busy bits and the registered read stage all hold their values.
- Writes take effect at the rising edge when upd=1 and wrN_en_i=1.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Both ports writing the same address: port 1 data wins.
  - Different addresses: both writes commit in the same cycle.
- Scoreboard:
  - A commit on either write port clears the busy bit of its address.
  - rsv_en_i with upd=1 sets the busy bit of rsv_addr_i.
  - Reserve and write to the same address in one cycle: the bit ends set (the new producer wins).
  - Reserve of address 0 is ignored when ZERO_REG=1.
  - A write to a non-busy register is legal and leaves the bit clear.
- Combinational read (READ_REG=0): rd_data_o[k] = regs[addr_k], with these overrides:
  - ZERO_REG=1 and addr_k=0: returns 0.
  - BYPASS=1: if port 1 is writing addr_k with upd=1 this cycle, returns wr1_data_i. Otherwise, if port 0 is writing addr_k, returns wr0_data_i.
  - Bypass never applies to address 0 when ZERO_REG=1, and never applies when upd=0.
  - BYPASS=0: returns the pre-edge stored value.
- rd_busy_o[k] = busy[addr_k], after bypass: if a write to addr_k commits this cycle and no reserve of addr_k is active, it reads 0.
- Registered read (READ_REG=1):
  - When upd=1, rd_data_o and rd_busy_o are updated at the edge with the post-write values of the addresses presented that cycle. Latency is 1 cycle.
  - When upd=0, outputs hold.
- busy_vec_o is the raw registered scoreboard (no bypass). Bit 0 is tied 0 when ZERO_REG=1.
- Out-of-range addresses (AW bits always decode) cannot occur because NREGS is a power of 2.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then rst=1 for one cycle -> r5 reads 0, busy_vec_o=0.
- Dual write: same cycle wr0 r3=0x11, wr1 r7=0x22 -> r3=0x11, r7=0x22. Repeat with both ports on r9 (0xAA on port 0, 0xBB on port 1) -> r9=0xBB.
- Bypass (READ_REG=0, BYPASS=1): read r4 while wr0 writes 0x1234 to r4 -> rd_data_o=0x1234 in the same cycle. With BYPASS=0 the old value is seen and 0x1234 appears next cycle.
- Zero register: wr0 r0=0xFFFF_FFFF and rsv r0 -> r0 reads 0, busy_vec_o[0]=0.
- Scoreboard:
  - rsv r6 -> busy[6]=1 next cycle.
  - wr1 r6=0x55 -> busy[6]=0 and rd_busy_o=0 during the write cycle.
  - Simultaneous rsv r6 and wr0 r6 -> busy[6]=1, r6 = new data.
- Freeze / registered read (READ_REG=1):
  - freeze_i=1 with wr0 r2=0x77 -> r2 unchanged and rd_data_o held.
  - Release freeze and read r2 after writing 0x77 -> 0x77 appears one cycle after the address is presented.
